// File: rtl/bus_req_pkg.sv
// Shared types and defaults for the request/grant bus master.
package bus_req_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_ACK = 2'd2
  } bus_req_state_e;

  localparam int DEFAULT_DW      = 32;
  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 16;

  localparam logic [1:0] RETRY_LIMIT = 2'd3;

endpackage

// File: rtl/bus_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; head word is visible on rdata.
module bus_cmd_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   push,
  input  logic [DW-1:0]          wdata,
  input  logic                   pop,
  output logic [DW-1:0]          rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/bus_req_master.sv
// Request/grant bus master: buffers commands, issues one bus_req per word, supervises bus_ack.
// Optional retry-on-timeout is enabled with the BUS_REQ_MASTER_RETRY_EN macro.
module bus_req_master
  import bus_req_pkg::*;
#(
  parameter int DW      = DEFAULT_DW,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DW-1:0]          cmd_data,
  output logic                   bus_req,
  output logic [DW-1:0]          bus_data,
  input  logic                   bus_ack,
  output logic                   done,
  output logic                   timeout_err,
  output logic                   proto_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output bus_req_state_e         state_dbg
`ifdef BUS_REQ_MASTER_RETRY_EN
  ,
  output logic [1:0]             retry_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);

  // Command port: a word transfers on every posedge where cmd_valid && cmd_ready;
  // cmd_data must be stable while cmd_valid is high, cmd_ready does not depend on cmd_valid.
  bus_req_state_e state_q, state_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           push, pop;
  logic           fifo_full, fifo_empty;
  logic [DW-1:0]  fifo_rdata;
  logic [CW-1:0]  cnt_next;
  logic           done_d, tmo_err_d, proto_d;
`ifdef BUS_REQ_MASTER_RETRY_EN
  logic [1:0]     retry_q, retry_d;
  assign retry_cnt = retry_q;
`endif

  assign push      = cmd_valid && cmd_ready && !fifo_full;
  assign cnt_next  = fifo_count + CW'(push) - CW'(pop);
  assign bus_req   = (state_q == REQ);
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign state_dbg = state_q;

  bus_cmd_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_l (reset_l),
    .push    (push),
    .wdata   (cmd_data),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    pop       = 1'b0;
    done_d    = 1'b0;
    tmo_err_d = 1'b0;
`ifdef BUS_REQ_MASTER_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = REQ;
`ifdef BUS_REQ_MASTER_RETRY_EN
          retry_d = 2'd0;
`endif
        end
      end
      REQ: begin
        tmo_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        tmo_d = tmo_q + 1'b1;
        // An ack in the final counted cycle still completes the transaction.
        if (bus_ack) begin
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef BUS_REQ_MASTER_RETRY_EN
          retry_d = 2'd0;
`endif
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
`ifdef BUS_REQ_MASTER_RETRY_EN
          if (retry_q != RETRY_LIMIT) begin
            retry_d = retry_q + 2'd1;
            state_d = REQ;
          end else begin
            tmo_err_d = 1'b1;
            state_d   = IDLE;
          end
`else
          tmo_err_d = 1'b1;
          state_d   = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    proto_d = bus_ack && ((state_q == IDLE) || (state_q == REQ));
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      cmd_ready   <= 1'b0;
      bus_data    <= '0;
`ifdef BUS_REQ_MASTER_RETRY_EN
      retry_q     <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      done        <= done_d;
      timeout_err <= tmo_err_d;
      proto_err   <= proto_d;
      // Registered from the next count, so a pop while full frees a slot one cycle later.
      cmd_ready   <= (cnt_next != CW'(DEPTH));
      if (pop) bus_data <= fifo_rdata;
`ifdef BUS_REQ_MASTER_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_req_master.sv
// Directed bench for bus_req_master: cycle table for the main flows, hand sequences for timeouts.
module tb_bus_req_master;
  import bus_req_pkg::*;

  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            reset_l = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [DW-1:0]   cmd_data = '0;
  logic            bus_req;
  logic [DW-1:0]   bus_data;
  logic            bus_ack = 1'b0;
  logic            done;
  logic            timeout_err;
  logic            proto_err;
  logic            busy;
  logic [2:0]      fifo_count;
  bus_req_state_e  state_dbg;
`ifdef BUS_REQ_MASTER_RETRY_EN
  logic [1:0]      retry_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bus_req_master #(
    .DW      (DW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_l     (reset_l),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .bus_req     (bus_req),
    .bus_data    (bus_data),
    .bus_ack     (bus_ack),
    .done        (done),
    .timeout_err (timeout_err),
    .proto_err   (proto_err),
    .busy        (busy),
    .fifo_count  (fifo_count),
`ifdef BUS_REQ_MASTER_RETRY_EN
    .retry_cnt   (retry_cnt),
`endif
    .state_dbg   (state_dbg)
  );

  // ctl = {reset_l, cmd_valid, bus_ack}; flg = {bus_req, done, timeout_err, proto_err, busy, cmd_ready}
  typedef struct {
    logic [2:0]    ctl;
    logic [DW-1:0] din;
    logic [5:0]    flg;
    logic [DW-1:0] edata;
    logic [2:0]    ecnt;
    logic [1:0]    est;
  } vec_t;

  localparam int NV = 41;
  vec_t vecs [NV];

  function automatic vec_t mv(input logic [2:0] ctl, input logic [DW-1:0] din,
                              input logic [5:0] flg, input logic [DW-1:0] edata,
                              input logic [2:0] ecnt, input bus_req_state_e est);
    vec_t v;
    v.ctl   = ctl;
    v.din   = din;
    v.flg   = flg;
    v.edata = edata;
    v.ecnt  = ecnt;
    v.est   = est;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (bus_req) found = 1'b1;
    end
  endtask

  initial begin
    vecs[0]  = mv(3'b000, 32'h0,    6'b000000, 32'h0,    3'd0, IDLE);
    vecs[1]  = mv(3'b000, 32'h0,    6'b000000, 32'h0,    3'd0, IDLE);
    vecs[2]  = mv(3'b100, 32'h0,    6'b000001, 32'h0,    3'd0, IDLE);
    vecs[3]  = mv(3'b110, 32'hfeed, 6'b000011, 32'h0,    3'd1, IDLE);
    vecs[4]  = mv(3'b100, 32'h0,    6'b100011, 32'hfeed, 3'd0, REQ);
    vecs[5]  = mv(3'b100, 32'h0,    6'b000011, 32'hfeed, 3'd0, WAIT_ACK);
    vecs[6]  = mv(3'b100, 32'h0,    6'b000011, 32'hfeed, 3'd0, WAIT_ACK);
    vecs[7]  = mv(3'b101, 32'h0,    6'b010001, 32'hfeed, 3'd0, IDLE);
    vecs[8]  = mv(3'b100, 32'h0,    6'b000001, 32'hfeed, 3'd0, IDLE);
    vecs[9]  = mv(3'b110, 32'ha0,   6'b000011, 32'hfeed, 3'd1, IDLE);
    vecs[10] = mv(3'b110, 32'h1,    6'b100011, 32'ha0,   3'd1, REQ);
    vecs[11] = mv(3'b110, 32'h2,    6'b000011, 32'ha0,   3'd2, WAIT_ACK);
    vecs[12] = mv(3'b110, 32'h3,    6'b000011, 32'ha0,   3'd3, WAIT_ACK);
    vecs[13] = mv(3'b110, 32'h4,    6'b000010, 32'ha0,   3'd4, WAIT_ACK);
    vecs[14] = mv(3'b111, 32'h5,    6'b010010, 32'ha0,   3'd4, IDLE);
    vecs[15] = mv(3'b100, 32'h0,    6'b100011, 32'h1,    3'd3, REQ);
    vecs[16] = mv(3'b100, 32'h0,    6'b000011, 32'h1,    3'd3, WAIT_ACK);
    vecs[17] = mv(3'b101, 32'h0,    6'b010011, 32'h1,    3'd3, IDLE);
    vecs[18] = mv(3'b100, 32'h0,    6'b100011, 32'h2,    3'd2, REQ);
    vecs[19] = mv(3'b100, 32'h0,    6'b000011, 32'h2,    3'd2, WAIT_ACK);
    vecs[20] = mv(3'b101, 32'h0,    6'b010011, 32'h2,    3'd2, IDLE);
    vecs[21] = mv(3'b100, 32'h0,    6'b100011, 32'h3,    3'd1, REQ);
    vecs[22] = mv(3'b100, 32'h0,    6'b000011, 32'h3,    3'd1, WAIT_ACK);
    vecs[23] = mv(3'b101, 32'h0,    6'b010011, 32'h3,    3'd1, IDLE);
    vecs[24] = mv(3'b100, 32'h0,    6'b100011, 32'h4,    3'd0, REQ);
    vecs[25] = mv(3'b100, 32'h0,    6'b000011, 32'h4,    3'd0, WAIT_ACK);
    vecs[26] = mv(3'b101, 32'h0,    6'b010001, 32'h4,    3'd0, IDLE);
    vecs[27] = mv(3'b100, 32'h0,    6'b000001, 32'h4,    3'd0, IDLE);
    vecs[28] = mv(3'b101, 32'h0,    6'b000101, 32'h4,    3'd0, IDLE);
    vecs[29] = mv(3'b100, 32'h0,    6'b000001, 32'h4,    3'd0, IDLE);
    vecs[30] = mv(3'b110, 32'h55,   6'b000011, 32'h4,    3'd1, IDLE);
    vecs[31] = mv(3'b100, 32'h0,    6'b100011, 32'h55,   3'd0, REQ);
    vecs[32] = mv(3'b101, 32'h0,    6'b000111, 32'h55,   3'd0, WAIT_ACK);
    vecs[33] = mv(3'b100, 32'h0,    6'b000011, 32'h55,   3'd0, WAIT_ACK);
    vecs[34] = mv(3'b101, 32'h0,    6'b010001, 32'h55,   3'd0, IDLE);
    vecs[35] = mv(3'b100, 32'h0,    6'b000001, 32'h55,   3'd0, IDLE);
    vecs[36] = mv(3'b110, 32'h77,   6'b000011, 32'h55,   3'd1, IDLE);
    vecs[37] = mv(3'b110, 32'h88,   6'b100011, 32'h77,   3'd1, REQ);
    vecs[38] = mv(3'b100, 32'h0,    6'b000011, 32'h77,   3'd1, WAIT_ACK);
    vecs[39] = mv(3'b000, 32'h0,    6'b000000, 32'h0,    3'd0, IDLE);
    vecs[40] = mv(3'b100, 32'h0,    6'b000001, 32'h0,    3'd0, IDLE);

    for (int i = 0; i < NV; i++) begin
      logic [42:0] act_v;
      logic [42:0] exp_v;
      {reset_l, cmd_valid, bus_ack} = vecs[i].ctl;
      cmd_data = vecs[i].din;
      tick();
      act_v = {bus_req, done, timeout_err, proto_err, busy, cmd_ready, bus_data, fifo_count, state_dbg};
      exp_v = {vecs[i].flg, vecs[i].edata, vecs[i].ecnt, vecs[i].est};
      check($sformatf("vec[%0d]", i), 64'(act_v), 64'(exp_v));
    end
    cmd_valid = 1'b0;
    bus_ack   = 1'b0;
    cmd_data  = '0;
`ifdef BUS_REQ_MASTER_RETRY_EN
    check("retry_cnt_after_reset", 64'(retry_cnt), 64'd0);
`endif

    // The word aborted by reset must never complete or time out.
    begin
      bit stray = 1'b0;
      for (int c = 0; c < 24; c++) begin
        tick();
        if (done || timeout_err || busy || bus_req) stray = 1'b1;
      end
      check("aborted_word_silent", 64'(stray), 64'd0);
    end

    // Never ack: timeout_err 17 cycles after the (last) bus_req.
    begin
      bit found;
      bit seen_terr = 1'b0;
      bit data_ok   = 1'b1;
      bit done_seen = 1'b0;
      int reqs = 0;
      int gap  = 0;
      push_word(32'hdead_beef);
      wait_req(found);
      check("timeout_req_seen", 64'(found), 64'd1);
      if (found) begin
        reqs = 1;
        if (bus_data !== 32'hdead_beef) data_ok = 1'b0;
        for (int c = 0; c < 200 && !seen_terr; c++) begin
          tick();
          gap++;
          if (bus_req) begin
            reqs++;
            gap = 0;
            if (bus_data !== 32'hdead_beef) data_ok = 1'b0;
          end
          if (done) done_seen = 1'b1;
          if (timeout_err) seen_terr = 1'b1;
        end
        check("timeout_err_seen", 64'(seen_terr), 64'd1);
        check("timeout_gap", 64'(gap), 64'd17);
        check("timeout_state_idle", 64'(state_dbg), 64'(IDLE));
        check("timeout_data_stable", 64'(data_ok), 64'd1);
        check("timeout_no_done", 64'(done_seen), 64'd0);
`ifdef BUS_REQ_MASTER_RETRY_EN
        check("timeout_req_count", 64'(reqs), 64'd4);
        check("timeout_retry_cnt", 64'(retry_cnt), 64'd3);
`else
        check("timeout_req_count", 64'(reqs), 64'd1);
`endif
        tick();
        check("timeout_err_one_cycle", 64'({timeout_err, busy}), 64'd0);
      end
    end

    // Ack in the very cycle the counter holds TIMEOUT-1: ack wins.
    begin
      bit found;
      bit early = 1'b0;
      push_word(32'hbeef_0001);
      wait_req(found);
      check("boundary_req_seen", 64'(found), 64'd1);
      if (found) begin
        for (int c = 0; c < 16; c++) begin
          tick();
          if (done || timeout_err || bus_req) early = 1'b1;
        end
        check("boundary_no_early_event", 64'(early), 64'd0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("boundary_done_terr", 64'({done, timeout_err, proto_err}), 64'b100);
        tick();
        check("boundary_after", 64'({done, timeout_err, busy, state_dbg}), 64'(IDLE));
`ifdef BUS_REQ_MASTER_RETRY_EN
        check("boundary_retry_cnt", 64'(retry_cnt), 64'd0);
`endif
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_req_master.md
Name: bus_req_master

Overview:
- Upstream driver for the single-cycle request/grant bus: bus_req, bus_ack, 32-bit bus_data, all sampled on posedge clk.
- Accepts command words from a local producer over a valid/ready port and buffers them in a small FIFO.
- Issues one bus_req pulse per word, then waits for the matching bus_ack pulse.
- Supervises the handshake: detects timeouts and protocol violations, and reports completion.

Parameters:
- DW, 32, bus_data and cmd_data width.
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- TIMEOUT, 16, cycles in WAIT_ACK before the transaction is abandoned; at least 2.

Ports:
- clk  in  1  bus clock; all logic on posedge.
- reset_l  in  1  synchronous reset, active-low.
- cmd_valid  in  1  producer offers cmd_data.
- cmd_ready  out  1  FIFO not full.
- cmd_data  in  DW  command word.
- bus_req  out  1  single-cycle request pulse.
- bus_data  out  DW  request payload.
- bus_ack  in  1  single-cycle acknowledge pulse.
- done  out  1  pulse: transaction acknowledged.
- timeout_err  out  1  pulse: transaction abandoned.
- proto_err  out  1  pulse: unexpected bus_ack.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - Applies on the clk edge where reset_l=0.
  - All outputs return to 0 and the FSM returns to IDLE.
  - The FIFO empties and cmd_ready=0 during reset; cmd_ready=1 from the first cycle after release.
  - Reset mid-transaction discards the transaction silently; no done or error pulse.
- FIFO:
  - Push when cmd_valid and cmd_ready.
  - Pop when the FSM leaves IDLE.
  - Push and pop may occur in the same cycle; when full, a simultaneous pop does NOT raise cmd_ready that cycle, because cmd_ready is registered from the count.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, REQ, WAIT_ACK.
  - IDLE: if the FIFO is non-empty, pop the head into bus_data and go to REQ.
  - REQ: exactly one cycle; bus_req=1; load the timeout counter with 0; go to WAIT_ACK.
  - WAIT_ACK: bus_req=0 and the counter increments each cycle.
    - bus_ack=1: pulse done next cycle and go to IDLE.
    - Counter reaches TIMEOUT-1 with no ack: pulse timeout_err and go to IDLE.
    - Ack and timeout in the same cycle: the ack wins.
- bus_data:
  - Stable from the REQ cycle until the FSM returns to IDLE.
  - Holds its last value while idle; it is not cleared.
- Throughput: back-to-back words need a minimum of 3 cycles per transaction (IDLE, REQ, WAIT_ACK with immediate ack).
- proto_err: one-cycle pulse whenever bus_ack=1 while the FSM is in IDLE or REQ; the FSM is otherwise unaffected.
- Pulse timing: done, timeout_err and proto_err are registered, one cycle wide, and assert the cycle after the cause.

Optional Feature:
- Macro: BUS_REQ_MASTER_RETRY_EN.
- Defined:
  - On timeout the FSM returns to REQ with the same bus_data instead of dropping the transaction.
  - A 2-bit retry counter allows up to 3 retries.
  - timeout_err pulses only when the final retry times out.
  - The retry counter clears on done or on a new pop.
  - Adds output retry_cnt (2 bits) for visibility.
- Undefined: a timeout drops the transaction immediately and retry_cnt does not exist.

Decomposition:
- Package bus_req_pkg holds:
  - State enum (IDLE=2'd0, REQ=2'd1, WAIT_ACK=2'd2).
  - Default DW, DEPTH and TIMEOUT localparams.
  - Retry limit constant (3).
- One sub-module, bus_cmd_fifo: synchronous FIFO with count, full and empty outputs, parameterised on DW and DEPTH.
- FSM and timeout counter live in bus_req_master.

Test Plan:
- Reset, then push 32'hfeed; ack 2 cycles after the bus_req pulse.
  - Required: bus_req high exactly 1 cycle with bus_data=32'hfeed.
  - Required: done pulses 1 cycle after the ack; busy falls.
- Push 4 words 32'h1..32'h4 back-to-back with the bench acking immediately.
  - Required: cmd_ready drops at fifo_count=4.
  - Required: 4 req pulses in order, spaced 3 cycles apart, and 4 done pulses.
- Never ack, with TIMEOUT=16.
  - Required: timeout_err pulses 17 cycles after bus_req and the FSM returns to IDLE.
  - Required with BUS_REQ_MASTER_RETRY_EN: 4 bus_req pulses carrying identical data, then one timeout_err with retry_cnt=3.
- Inject bus_ack while idle, and in the same cycle as bus_req.
  - Required: proto_err pulses each time.
  - Required: no done pulse and no state change.
- Assert reset_l=0 for 1 cycle during WAIT_ACK.
  - Required: all outputs 0, fifo_count=0, and no done or timeout_err ever appears for the aborted word.
- Ack on exactly the cycle the counter reaches TIMEOUT-1.
  - Required: done pulses and timeout_err stays 0.
